// File: rtl/nreg_write_arbiter.sv
// nreg_write_arbiter
//   Shares one WIDTH-bit storage register among N_REQ writers. The writers are
//   arbitrated round-robin with a valid/ready handshake. A writer that asks to
//   lock keeps the grant for a bounded burst of at most MAX_HOLD grants. The
//   winning lane is registered into io_Q at the next clock edge.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   io_req_valid  per-requester write request
//   io_req_lock   per-requester request to keep the grant next cycle
//   io_req_data   lane i = bits [i*WIDTH +: WIDTH]
//   io_req_ready  one-hot combinational grant; all zero while reset is high
//   io_Q          shared register contents
//   io_grant_vld  a write landed on the last edge
//   io_grant_id   index of the last writer (holds when no write happens)
//   io_wr_count   total accepted writes, saturating at all-ones
module nreg_write_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned IdW     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       io_req_valid,
  input  logic [N_REQ-1:0]       io_req_lock,
  input  logic [N_REQ*WIDTH-1:0] io_req_data,
  output logic [N_REQ-1:0]       io_req_ready,
  output logic [WIDTH-1:0]       io_Q,
  output logic                   io_grant_vld,
  output logic [IdW-1:0]         io_grant_id,
  output logic [CNT_W-1:0]       io_wr_count
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {StArb, StHold} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [IdW-1:0]     owner_q, owner_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               gvld_q, gvld_d;
  logic [IdW-1:0]     gid_q, gid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               found;
  logic [IdW-1:0]     gnt_idx;
  logic [IdW-1:0]     idx;

  // Arbitration and next-state
  always_comb begin
    found        = 1'b0;
    gnt_idx      = '0;
    idx          = '0;
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    hold_cnt_d   = hold_cnt_q;
    io_req_ready = '0;

    if (!reset) begin
      unique case (state_q)
        StArb: begin
          // First valid lane starting from the round-robin pointer.
          for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = IdW'((32'(ptr_q) + k) % N_REQ);
            if (!found && io_req_valid[idx]) begin
              found   = 1'b1;
              gnt_idx = idx;
            end
          end
          if (found) begin
            ptr_d = IdW'((32'(gnt_idx) + 32'd1) % N_REQ);
            if (io_req_lock[gnt_idx] && (MAX_HOLD > 1)) begin
              state_d    = StHold;
              owner_d    = gnt_idx;
              hold_cnt_d = HoldW'(1);
            end
          end
        end
        StHold: begin
          // Only the owner may win; if it is idle the burst ends and the
          // cycle is lost rather than handed to another lane.
          if (io_req_valid[owner_q]) begin
            found      = 1'b1;
            gnt_idx    = owner_q;
            hold_cnt_d = hold_cnt_q + HoldW'(1);
            if (!(io_req_lock[owner_q] && (32'(hold_cnt_q) + 32'd1 < MAX_HOLD))) begin
              state_d = StArb;
            end
          end else begin
            state_d = StArb;
          end
        end
        default: state_d = StArb;
      endcase
    end

    if (found) begin
      io_req_ready[gnt_idx] = 1'b1;
    end
  end

  // Shared register and status
  always_comb begin
    q_d    = q_q;
    gvld_d = found;
    gid_d  = gid_q;
    cnt_d  = cnt_q;
    if (found) begin
      q_d   = io_req_data[32'(gnt_idx) * WIDTH +: WIDTH];
      gid_d = gnt_idx;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StArb;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      q_q        <= '0;
      gvld_q     <= 1'b0;
      gid_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      q_q        <= q_d;
      gvld_q     <= gvld_d;
      gid_q      <= gid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign io_Q         = q_q;
  assign io_grant_vld = gvld_q;
  assign io_grant_id  = gid_q;
  assign io_wr_count  = cnt_q;

endmodule

// File: tb/tb_nreg_write_arbiter.sv
// tb_nreg_write_arbiter
//   Scoreboard bench: the driver applies one cycle of inputs and a behavioural
//   model predicts the grant and the resulting register write. Expected values
//   are queued; a monitor on the falling edge pops and compares them.
module tb_nreg_write_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned MH = 4;
  localparam int unsigned CW = 4;
  localparam int MaxCnt = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     valid, lock, ready;
  logic [N*W-1:0]   data;
  logic [W-1:0]     q;
  logic             gvld;
  logic [1:0]       gid;
  logic [CW-1:0]    cnt;

  always #5 clk = ~clk;

  nreg_write_arbiter #(
    .N_REQ   (N),
    .WIDTH   (W),
    .MAX_HOLD(MH),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .io_req_valid(valid),
    .io_req_lock (lock),
    .io_req_data (data),
    .io_req_ready(ready),
    .io_Q        (q),
    .io_grant_vld(gvld),
    .io_grant_id (gid),
    .io_wr_count (cnt)
  );

  typedef struct {
    logic [W-1:0] q;
    int           id;
    int           cnt;
  } wr_t;

  wr_t          wr_q[$];
  logic [N-1:0] rdy_q[$];
  int checks   = 0;
  int failures = 0;

  // Model: pointer, burst owner and how many further grants the burst allows.
  int m_ptr   = 0;
  int m_owner = 0;
  int m_left  = 0;
  int m_cnt   = 0;
  bit m_hold  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] v, input logic [N-1:0] lk,
                            input logic [N*W-1:0] d, output logic [N-1:0] rdy);
    int  g;
    wr_t e;
    rdy = '0;
    g   = -1;
    if (r) begin
      m_ptr  = 0;
      m_hold = 0;
      m_left = 0;
      m_cnt  = 0;
    end else if (m_hold) begin
      if (v[m_owner]) begin
        g = m_owner;
        m_left--;
        if (!(lk[g] && m_left > 0)) m_hold = 0;
      end else begin
        m_hold = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (lk[g] && MH > 1) begin
          m_hold  = 1;
          m_owner = g;
          m_left  = MH - 1;
        end
      end
    end
    if (g >= 0) begin
      rdy[g] = 1'b1;
      if (m_cnt < MaxCnt) m_cnt++;
      e.q   = d[g*W +: W];
      e.id  = g;
      e.cnt = m_cnt;
      wr_q.push_back(e);
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] v, input logic [N-1:0] lk,
                       input logic [N*W-1:0] d);
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #1;
    reset = r;
    valid = v;
    lock  = lk;
    data  = d;
    model_step(r, v, lk, d, exp_rdy);
    rdy_q.push_back(exp_rdy);
  endtask

  // Monitor
  initial begin
    bit           armed    = 0;
    bit           prev_rst = 0;
    logic [W-1:0] lq       = '0;
    int           lid      = 0;
    int           lcnt     = 0;
    logic [N-1:0] er;
    wr_t          e;
    forever begin
      @(negedge clk);
      if (rdy_q.size() > 0) begin
        er = rdy_q.pop_front();
        chk("ready", 64'(ready), 64'(er));
      end
      if (prev_rst) begin
        chk("rst_vld", 64'(gvld), 64'd0);
        chk("rst_q", 64'(q), 64'd0);
        chk("rst_id", 64'(gid), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        lq    = '0;
        lid   = 0;
        lcnt  = 0;
        armed = 1;
      end else if (armed) begin
        if (gvld === 1'b1) begin
          if (wr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_unexpected: got grant_vld 1 expected no write at %0t", $time);
          end else begin
            e = wr_q.pop_front();
            chk("wr_q", 64'(q), 64'(e.q));
            chk("wr_id", 64'(gid), 64'(e.id));
            chk("wr_cnt", 64'(cnt), 64'(e.cnt));
            lq   = e.q;
            lid  = e.id;
            lcnt = e.cnt;
          end
        end else begin
          chk("idle_vld", 64'(gvld), 64'd0);
          chk("idle_q", 64'(q), 64'(lq));
          chk("idle_id", 64'(gid), 64'(lid));
          chk("idle_cnt", 64'(cnt), 64'(lcnt));
        end
      end
      prev_rst = reset;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    reset = 1'b1;
    valid = '0;
    lock  = '0;
    data  = '0;
    repeat (3) drive(1'b1, '0, '0, '0);

    // Single write from lane 2.
    drive(1'b0, 4'b0100, 4'b0000, 32'h00A5_0000);
    drive(1'b0, 4'b0000, 4'b0000, 32'h0);

    // Full rotation twice.
    repeat (2) drive(1'b1, '0, '0, '0);
    repeat (8) drive(1'b0, 4'b1111, 4'b0000, 32'h1312_1110);

    // Locked burst on lane 1, bounded by MAX_HOLD, then lanes 3 and 0.
    drive(1'b1, '0, '0, '0);
    drive(1'b0, 4'b0001, 4'b0000, 32'h0000_00C0);
    repeat (7) drive(1'b0, 4'b1011, 4'b0010, $urandom);

    // Owner drops valid inside a burst: one dead cycle, then resume from lane 2.
    drive(1'b1, '0, '0, '0);
    drive(1'b0, 4'b0001, 4'b0000, $urandom);
    drive(1'b0, 4'b0010, 4'b0010, $urandom);
    drive(1'b0, 4'b1101, 4'b0010, $urandom);
    drive(1'b0, 4'b1111, 4'b0000, $urandom);

    // Reset in the middle of a burst.
    drive(1'b1, '0, '0, '0);
    drive(1'b0, 4'b1000, 4'b1000, $urandom);
    drive(1'b1, 4'b1000, 4'b1000, $urandom);
    repeat (2) drive(1'b0, 4'b1111, 4'b0000, $urandom);

    // Write counter saturation.
    drive(1'b1, '0, '0, '0);
    repeat (20) drive(1'b0, 4'b1111, 4'b0000, $urandom);
    drive(1'b0, 4'b0000, 4'b0000, 32'h0);
    @(negedge clk);
    #1;
    chk("sat_count", 64'(cnt), 64'(MaxCnt));

    // Random traffic with occasional resets.
    repeat (3000) begin
      logic          r;
      logic [N-1:0]  v, lk;
      r  = ($urandom_range(0, 99) == 0);
      v  = N'($urandom);
      lk = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
      drive(r, v, lk, $urandom);
    end

    repeat (3) drive(1'b0, '0, '0, '0);
    @(negedge clk);
    #1;
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    chk("rdy_q_empty", 64'(rdy_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
